// File: rtl/ping_sequencer_if.sv
// ping_sequencer_if: start/abort request bus plus bridge, T/R switch and status outputs.
// ping_count is present only when PING_SEQUENCER_COUNT_EN is defined.
interface ping_sequencer_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] burst_cycles;
    logic [LEN_W-1:0] listen_cycles;
    logic [1:0]       hstate;
    logic             txrx;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;
`ifdef PING_SEQUENCER_COUNT_EN
    logic [15:0]      ping_count;

    modport master (
        output start, abort, burst_cycles, listen_cycles,
        input  hstate, txrx, busy, done, aborted, err, ping_count
    );
    modport slave (
        input  start, abort, burst_cycles, listen_cycles,
        output hstate, txrx, busy, done, aborted, err, ping_count
    );
`else
    modport master (
        output start, abort, burst_cycles, listen_cycles,
        input  hstate, txrx, busy, done, aborted, err
    );
    modport slave (
        input  start, abort, burst_cycles, listen_cycles,
        output hstate, txrx, busy, done, aborted, err
    );
`endif
endinterface

// File: rtl/ping_sequencer.sv
// ping_sequencer: fires one transducer ping as BURST -> BRAKE -> GUARD -> LISTEN,
// driving the h-bridge state code and the T/R switch. All outputs are registered.
// Optional build macro PING_SEQUENCER_COUNT_EN adds a 16-bit completed-ping counter.
module ping_sequencer #(
    parameter int BRAKE_CYCLES = 16,
    parameter int GUARD_CYCLES = 8,
    parameter int LEN_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    ping_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BURST, BRAKE, GUARD, LISTEN} state_t;

    localparam logic [1:0]       HS_OFF     = 2'b00;
    localparam logic [1:0]       HS_OSCL    = 2'b01;
    localparam logic [1:0]       HS_BRAKE   = 2'b10;
    localparam logic [LEN_W-1:0] BRAKE_LOAD = LEN_W'(BRAKE_CYCLES);
    localparam logic [LEN_W-1:0] GUARD_LOAD = LEN_W'(GUARD_CYCLES);
    localparam logic [LEN_W-1:0] CNT_LAST   = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] listen_len;
    logic             abort_pend;
    logic [1:0]       hstate_q;
    logic             txrx_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             err_q;

    assign bus.hstate  = hstate_q;
    assign bus.txrx    = txrx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.err     = err_q;

    // Phase sequencing: each phase counter is loaded on entry and the phase ends when it reads 1.
    // An abort during BURST/BRAKE is remembered so the bridge still brakes fully before going idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            listen_len <= '0;
            abort_pend <= 1'b0;
            hstate_q   <= HS_OFF;
            txrx_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.burst_cycles != '0) begin
                            state      <= BURST;
                            cnt        <= bus.burst_cycles;
                            listen_len <= bus.listen_cycles;
                            abort_pend <= 1'b0;
                            hstate_q   <= HS_OSCL;
                            busy_q     <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (bus.abort || cnt == CNT_LAST) begin
                        state      <= BRAKE;
                        cnt        <= BRAKE_LOAD;
                        abort_pend <= bus.abort;
                        hstate_q   <= HS_BRAKE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BRAKE: begin
                    if (bus.abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        hstate_q <= HS_OFF;
                        if (abort_pend || bus.abort) begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            aborted_q <= 1'b1;
                        end else begin
                            state <= GUARD;
                            cnt   <= GUARD_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GUARD: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        if (listen_len != '0) begin
                            state  <= LISTEN;
                            cnt    <= listen_len;
                            txrx_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LISTEN: begin
                    if (bus.abort || cnt == CNT_LAST) begin
                        state     <= IDLE;
                        txrx_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= !bus.abort;
                        aborted_q <= bus.abort;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hstate_q <= HS_OFF;
                    txrx_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PING_SEQUENCER_COUNT_EN
    logic [15:0] ping_count_q;
    logic        finish_ok;

    // A ping completes normally exactly when the FSM schedules done for the next cycle.
    always_comb begin
        finish_ok = 1'b0;
        if (!bus.abort && cnt == CNT_LAST) begin
            if (state == LISTEN) finish_ok = 1'b1;
            if (state == GUARD && listen_len == '0) finish_ok = 1'b1;
        end
    end

    // Completed-ping counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ping_count_q <= 16'h0000;
        end else if (finish_ok) begin
            ping_count_q <= ping_count_q + 16'h0001;
        end
    end

    assign bus.ping_count = ping_count_q;
`endif
endmodule

// File: tb/tb_ping_sequencer.sv
// tb_ping_sequencer: directed scenarios for ping_sequencer with hand-derived phase timings.
module tb_ping_sequencer;
    localparam int BRK = 16;
    localparam int GRD = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] obs;

    always #5 clk = ~clk;

    ping_sequencer_if #(.LEN_W(16)) bus();

    ping_sequencer #(.BRAKE_CYCLES(16), .GUARD_CYCLES(8), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Observed status vector: {hstate, txrx, busy, done, aborted, err}
    assign obs = {bus.hstate, bus.txrx, bus.busy, bus.done, bus.aborted, bus.err};

    // Expected status for busy cycle i (0 = first cycle after start) of a non-aborted ping.
    function automatic logic [6:0] exp_vec(int b, int l, int i);
        if (i < b)                return 7'b01_0_1_000;
        if (i < b + BRK)          return 7'b10_0_1_000;
        if (i < b + BRK + GRD)    return 7'b00_0_1_000;
        if (i < b + BRK + GRD + l) return 7'b00_1_1_000;
        return 7'b00_0_0_100;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.burst_cycles = 16'd10;
        bus.listen_cycles = 16'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b want %b", i, obs, 7'b0);
            end
        end
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_normal;
        bus.burst_cycles = 16'd10;
        bus.listen_cycles = 16'd20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (obs !== exp_vec(10, 20, i)) begin
                errors++;
                $display("FAIL normal cyc %0d got %b want %b", i, obs, exp_vec(10, 20, i));
            end
            tick();
        end
        checks++;
        if (obs !== 7'b00_0_0_100) begin
            errors++;
            $display("FAIL normal_done got %b want %b", obs, 7'b00_0_0_100);
        end
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL normal_after got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_zero_burst;
        bus.burst_cycles = 16'd0;
        bus.listen_cycles = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs !== 7'b00_0_0_001) begin
            errors++;
            $display("FAIL zero_burst_err got %b want %b", obs, 7'b00_0_0_001);
        end
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL zero_burst_idle got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_zero_listen;
        bus.burst_cycles = 16'd4;
        bus.listen_cycles = 16'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 29; i++) begin
            checks++;
            if (obs !== exp_vec(4, 0, i)) begin
                errors++;
                $display("FAIL zero_listen cyc %0d got %b want %b", i, obs, exp_vec(4, 0, i));
            end
            tick();
        end
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL zero_listen_after got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_abort_burst;
        bus.burst_cycles = 16'd100;
        bus.listen_cycles = 16'd20;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== 7'b01_0_1_000) begin
                errors++;
                $display("FAIL abort_burst_osc cyc %0d got %b want %b", i, obs, 7'b01_0_1_000);
            end
            if (i == 2) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        for (int i = 0; i < BRK; i++) begin
            checks++;
            if (obs !== 7'b10_0_1_000) begin
                errors++;
                $display("FAIL abort_burst_brake cyc %0d got %b want %b", i, obs, 7'b10_0_1_000);
            end
            tick();
        end
        checks++;
        if (obs !== 7'b00_0_0_010) begin
            errors++;
            $display("FAIL abort_burst_end got %b want %b", obs, 7'b00_0_0_010);
        end
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL abort_burst_after got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_abort_listen;
        bus.burst_cycles = 16'd2;
        bus.listen_cycles = 16'd20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            checks++;
            if (obs !== exp_vec(2, 20, i)) begin
                errors++;
                $display("FAIL abort_listen cyc %0d got %b want %b", i, obs, exp_vec(2, 20, i));
            end
            if (i == 30) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        checks++;
        if (obs !== 7'b00_0_0_010) begin
            errors++;
            $display("FAIL abort_listen_end got %b want %b", obs, 7'b00_0_0_010);
        end
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL abort_listen_after got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_back_to_back;
        bus.burst_cycles = 16'd10;
        bus.listen_cycles = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (obs !== exp_vec(10, 5, i)) begin
                errors++;
                $display("FAIL restart_busy cyc %0d got %b want %b", i, obs, exp_vec(10, 5, i));
            end
            if (i == 3) begin
                bus.start = 1'b1;
                bus.burst_cycles = 16'd2;
                bus.listen_cycles = 16'd0;
            end
            if (i == 4) bus.start = 1'b0;
            tick();
        end
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL restart_busy_after got %b want %b", obs, 7'b0);
        end
    endtask

`ifdef PING_SEQUENCER_COUNT_EN
    task automatic test_count;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (bus.ping_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_reset got %h want %h", bus.ping_count, 16'h0000);
        end
        bus.listen_cycles = 16'd0;
        for (int p = 0; p < 3; p++) begin
            bus.burst_cycles = 16'd1;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            repeat (26) tick();
        end
        bus.burst_cycles = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (17) tick();
        checks++;
        if (bus.ping_count !== 16'd3) begin
            errors++;
            $display("FAIL count_three got %h want %h", bus.ping_count, 16'd3);
        end
        force dut.ping_count_q = 16'hFFFF;
        tick();
        release dut.ping_count_q;
        bus.burst_cycles = 16'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (26) tick();
        checks++;
        if (bus.ping_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap got %h want %h", bus.ping_count, 16'h0000);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_zero_burst();
        test_zero_listen();
        test_abort_burst();
        test_abort_listen();
        test_back_to_back();
`ifdef PING_SEQUENCER_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ping_sequencer.md
Name: ping_sequencer

Overview:
- Sequences one transducer ping for the DVL front end.
- Accepts a start strobe plus burst/listen lengths from the I2C register interface.
- Drives the 2-bit h-bridge state code through the phases burst, brake, guard and listen.
- Drives the T/R switch control `txrx`, and directly feeds `h_bridge.hstate` and the top-level `txrx` pin.

Parameters:
- BRAKE_CYCLES, 16: clk cycles spent in BRAKE after each burst; must be ≥1.
- GUARD_CYCLES, 8: clk cycles with bridge OFF and `txrx`=0 before the receive window opens; must be ≥1.
- LEN_W, 16: width of `burst_cycles` and `listen_cycles`.

Ports:
- clk  input  1  system clock (HSOSC-derived).
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to fire a ping.
- abort  input  1  level/pulse; terminates the ping in progress.
- burst_cycles  input  LEN_W  clk cycles of OSCL drive.
- listen_cycles  input  LEN_W  clk cycles of receive window.
- hstate  output  2  h-bridge code: 2'b00 OFF, 2'b01 OSCL, 2'b10 BRAKE (both low sides on), 2'b11 never driven.
- txrx  output  1  T/R switch: 1 = receiver connected, 0 = transmit/isolated.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse on normal ping completion.
- aborted  output  1  one-cycle pulse when a ping is terminated by `abort`.
- err  output  1  one-cycle pulse when `start` is rejected because `burst_cycles`==0.

Behaviour:
- Reset, asynchronous on rst=0: state=IDLE, hstate=OFF, txrx=0, busy=0, done=0, aborted=0, err=0, all counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BURST, BRAKE, GUARD, LISTEN.
- IDLE:
  - On start=1 with burst_cycles≠0: latch burst_cycles and listen_cycles, go to BURST.
  - The next cycle shows hstate=OSCL and busy=1 (one-cycle latency).
  - On start=1 with burst_cycles==0: stay IDLE, err=1 on the next cycle.
- BURST: hstate=OSCL, txrx=0, lasts exactly the latched burst_cycles cycles, then BRAKE.
- BRAKE: hstate=BRAKE, txrx=0, lasts exactly BRAKE_CYCLES cycles, then GUARD.
- GUARD: hstate=OFF, txrx=0, lasts exactly GUARD_CYCLES cycles. Then:
  - go to LISTEN if latched listen_cycles≠0;
  - otherwise go to IDLE with done=1 in the first IDLE cycle.
- LISTEN: hstate=OFF, txrx=1, lasts exactly listen_cycles cycles. Then IDLE; txrx=0, busy=0 and done=1 all in the same (first IDLE) cycle.
- Phase counters are loaded on phase entry and count down to 1; the full LEN_W range is supported (burst_cycles=0xFFFF gives 65535 cycles).
- `start` while busy: ignored, with no err. Inputs changing mid-ping do not affect the ping in progress.
- `abort` handling (abort has priority over phase-end in the same cycle):
  - In BURST: go to BRAKE (full BRAKE_CYCLES), then straight to IDLE, skipping GUARD and LISTEN; aborted pulses in the first IDLE cycle.
  - In BRAKE: finish BRAKE, then IDLE with aborted.
  - In GUARD or LISTEN: go to IDLE next cycle, txrx=0, aborted=1.
  - In IDLE: no effect.
  - `done` never asserts for an aborted ping.
- Simultaneous start+abort in IDLE: start wins; the ping begins.
- The bridge is never switched directly from OSCL to OFF; OSCL is always followed by BRAKE.
- txrx=1 only in LISTEN; hstate≠OFF is never concurrent with txrx=1.

Optional Feature:
- Macro: PING_SEQUENCER_COUNT_EN.
- When defined:
  - Adds output `ping_count[15:0]`, incremented by 1 in the same cycle `done` asserts; aborted or rejected pings do not count.
  - Wraps 0xFFFF→0x0000; reset value 0.
  - Intended for readback over I2C.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → hstate=00, txrx=0, busy=0, no pulses; release → still IDLE until a new start edge.
- Normal ping: start with burst=10, listen=20, defaults → hstate=01 for 10 cycles starting 1 cycle after start, 10 for 16, 00 for 8 with txrx=0, then txrx=1 for 20, then done pulse and busy=0; total busy = 54 cycles.
- Zero cases:
  - burst=0 → err pulse, busy stays 0.
  - burst=4, listen=0 → done immediately after GUARD, txrx never 1.
- Abort in BURST at cycle 3 of burst=100 → hstate 01→10 for 16 cycles → IDLE with aborted=1, done=0, txrx never 1.
- Abort in LISTEN, plus re-start while busy:
  - abort at listen cycle 5 → txrx=0 next cycle, aborted=1.
  - start pulsed mid-BURST → ignored; total ping length unchanged.
- With PING_SEQUENCER_COUNT_EN defined:
  - 3 normal pings + 1 aborted → ping_count=3.
  - Force count to 0xFFFF, complete a ping → 0x0000.
